// File: rtl/board_render_ctrl.sv
// Chess board renderer: a 3-stage pixel pipeline over a 64-square piece store,
// plus a write FSM that commits board updates only during vertical blank.
module board_render_ctrl (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        wr_req,
  input  logic [5:0]  wr_sq,
  input  logic [3:0]  wr_piece,
  input  logic        sel_valid,
  input  logic [5:0]  sel_sq,
  input  logic [3:0]  rom_q,
  input  logic [11:0] pal_rgb,
  output logic [11:0] rom_addr,
  output logic [3:0]  rom_piece,
  output logic        wr_ack,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int unsigned X0      = 80;
  localparam int unsigned SQ_PX   = 60;
  localparam int unsigned BOARD_H = 480;
  localparam logic [11:0] LIGHT   = 12'hEDB;
  localparam logic [11:0] DARK    = 12'h853;
  localparam logic [11:0] SEL     = 12'h6C4;

  typedef enum logic [2:0] {IDLE, WAIT_VB, COMMIT, ACK, HOLD} wr_state_t;

  wr_state_t   state;
  logic [3:0]  board [64];
  logic [5:0]  wr_sq_q;
  logic [3:0]  wr_piece_q;

  logic [9:0]  rel_x_c;
  logic        in_board_c;
  logic        vblank_c;
  logic        commit_c;
  logic [2:0]  row_c;
  logic [2:0]  col_c;
  logic [5:0]  ox_c;
  logic [5:0]  oy_c;
  logic [5:0]  sq_c;
  logic [11:0] sq_col_c;

  logic        in_board_1, blank_1, in_board_2, blank_2;
  logic [5:0]  sq_1, ox_1, oy_1;
  logic [11:0] sq_col_1, sq_col_2;

  function automatic logic [3:0] start_code(input logic [5:0] idx);
    logic [3:0] back [8];
    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    case (idx[5:3])
      3'd0:    start_code = back[idx[2:0]] + 4'd8;
      3'd1:    start_code = 4'd9;
      3'd6:    start_code = 4'd1;
      3'd7:    start_code = back[idx[2:0]];
      default: start_code = 4'd0;
    endcase
  endfunction

  // Pixel geometry decode; values are don't-care outside the board.
  always_comb begin
    rel_x_c    = DrawX - 10'(X0);
    in_board_c = (DrawX >= 10'(X0)) && (DrawX < 10'(X0 + 8 * SQ_PX)) && (DrawY < 10'(BOARD_H));
    col_c      = 3'(rel_x_c / 10'(SQ_PX));
    row_c      = 3'(DrawY / 10'(SQ_PX));
    ox_c       = 6'(rel_x_c % 10'(SQ_PX));
    oy_c       = 6'(DrawY % 10'(SQ_PX));
    sq_c       = {row_c, col_c};
    if (sel_valid && (sel_sq == sq_c)) sq_col_c = SEL;
    else if (row_c[0] ^ col_c[0])      sq_col_c = DARK;
    else                               sq_col_c = LIGHT;
    vblank_c   = DrawY >= 10'(BOARD_H);
    commit_c   = (state == COMMIT) && vblank_c;
  end

  // Stage 1 (edge k): register decoded pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_board_1 <= 1'b0;
      blank_1    <= 1'b0;
      sq_1       <= '0;
      ox_1       <= '0;
      oy_1       <= '0;
      sq_col_1   <= '0;
    end else begin
      in_board_1 <= in_board_c;
      blank_1    <= blank;
      sq_1       <= sq_c;
      ox_1       <= ox_c;
      oy_1       <= oy_c;
      sq_col_1   <= sq_col_c;
    end
  end

  // Stage 2 (edge k+1): sprite address and piece lookup.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr   <= '0;
      rom_piece  <= '0;
      in_board_2 <= 1'b0;
      blank_2    <= 1'b0;
      sq_col_2   <= '0;
    end else begin
      rom_addr   <= 12'(oy_1) * 12'(SQ_PX) + 12'(ox_1);
      rom_piece  <= in_board_1 ? board[sq_1] : 4'd0;
      in_board_2 <= in_board_1;
      blank_2    <= blank_1;
      sq_col_2   <= sq_col_1;
    end
  end

  // Stage 3 (edge k+2): colour select once the ROM data has arrived.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      {red, green, blue} <= '0;
    end else if (!blank_2 || !in_board_2) begin
      {red, green, blue} <= '0;
    end else if ((rom_piece == 4'd0) || (rom_q == 4'd0)) begin
      {red, green, blue} <= sq_col_2;
    end else begin
      {red, green, blue} <= pal_rgb;
    end
  end

  // Board store; reset restores the opening position.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) board[i] <= start_code(6'(i));
    end else if (commit_c) begin
      board[wr_sq_q] <= wr_piece_q;
    end
  end

  // Write FSM; COMMIT re-checks vblank so the store never changes mid-frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ack     <= 1'b0;
      wr_sq_q    <= '0;
      wr_piece_q <= '0;
    end else begin
      wr_ack <= 1'b0;
      case (state)
        IDLE: if (wr_req) begin
          wr_sq_q    <= wr_sq;
          wr_piece_q <= wr_piece;
          state      <= WAIT_VB;
        end
        WAIT_VB: if (vblank_c) state <= COMMIT;
        COMMIT: begin
          if (vblank_c) begin
            state  <= ACK;
            wr_ack <= 1'b1;
          end else begin
            state <= WAIT_VB;
          end
        end
        ACK:     state <= HOLD;
        HOLD:    if (!wr_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_render_ctrl.sv
// Scoreboard bench for board_render_ctrl: random pixels against a board model,
// plus directed write-FSM and reset scenarios.
module tb_board_render_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0;
  logic        wr_req = 1'b0;
  logic [5:0]  wr_sq = '0;
  logic [3:0]  wr_piece = '0;
  logic        sel_valid = 1'b0;
  logic [5:0]  sel_sq = '0;
  logic [3:0]  rom_q = '0;
  logic [11:0] pal_rgb = '0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_piece;
  logic        wr_ack;
  logic [3:0]  red, green, blue;

  board_render_ctrl dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .wr_req(wr_req), .wr_sq(wr_sq), .wr_piece(wr_piece), .sel_valid(sel_valid),
    .sel_sq(sel_sq), .rom_q(rom_q), .pal_rgb(pal_rgb), .rom_addr(rom_addr),
    .rom_piece(rom_piece), .wr_ack(wr_ack), .red(red), .green(green), .blue(blue)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic        chk_addr;
    logic [11:0] addr;
    logic [3:0]  piece;
    logic [11:0] rgb;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         ack_cnt = 0;
  logic [3:0] model_board [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Synthetic sprite ROM contents and palette.
  function automatic logic [3:0] rom_f(input int addr, input int piece);
    if (addr % 4 == 0) return 4'd0;
    return 4'(((addr / 4) + piece) % 15 + 1);
  endfunction

  function automatic logic [11:0] pal_f(input logic [3:0] piece, input logic [3:0] q);
    return {piece, q, piece ^ q};
  endfunction

  always @(negedge vga_clk) begin
    rom_q   <= rom_f(int'(rom_addr), int'(rom_piece));
    pal_rgb <= pal_f(rom_piece, rom_f(int'(rom_addr), int'(rom_piece)));
  end

  always @(negedge vga_clk) if (wr_ack === 1'b1) ack_cnt++;

  task automatic model_reset();
    int back [8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int c = 0; c < 8; c++) begin
      model_board[c]      = 4'(back[c] + 8);
      model_board[8 + c]  = 4'd9;
      model_board[48 + c] = 4'd1;
      model_board[56 + c] = 4'(back[c]);
      for (int r = 2; r < 6; r++) model_board[r * 8 + c] = 4'd0;
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #2;
  endtask

  // Drive one pixel and queue its expected pipeline response.
  task automatic drive_pixel(input int x, input int y, input bit b, input bit sv, input int ss);
    exp_t e;
    bit   inb;
    int   row, col, sq, addr, q;
    logic [11:0] sqcol;
    DrawX = 10'(x); DrawY = 10'(y); blank = b; sel_valid = sv; sel_sq = 6'(ss);
    inb = (x >= 80) && (x < 560) && (y < 480);
    e.chk_addr = inb;
    e.addr = '0; e.piece = '0; e.rgb = '0;
    if (inb) begin
      row  = y / 60;
      col  = (x - 80) / 60;
      sq   = row * 8 + col;
      addr = (y % 60) * 60 + (x - 80) % 60;
      e.addr  = 12'(addr);
      e.piece = model_board[sq];
      q = rom_f(addr, int'(e.piece));
      if (sv && ss == sq)          sqcol = 12'h6C4;
      else if ((row + col) % 2 == 0) sqcol = 12'hEDB;
      else                         sqcol = 12'h853;
      if (!b)                                e.rgb = 12'h000;
      else if (e.piece == 4'd0 || q == 0)    e.rgb = sqcol;
      else                                   e.rgb = pal_f(e.piece, 4'(q));
    end
    exp_q.push_back(e);
    tick();
  endtask

  task automatic rand_pixel(input bit board_only);
    int x, y, ss;
    x = board_only ? int'($urandom_range(80, 559)) : int'($urandom_range(0, 639));
    y = board_only ? int'($urandom_range(0, 479))  : int'($urandom_range(0, 524));
    ss = int'($urandom_range(0, 63));
    if ($urandom_range(0, 1) == 1 && x >= 80 && x < 560 && y < 480)
      ss = (y / 60) * 8 + (x - 80) / 60;
    drive_pixel(x, y, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), ss);
  endtask

  // Monitor: pops one record per issued pixel and checks it at k+1 and k+2.
  exp_t s1, s2;
  bit   s1v = 1'b0, s2v = 1'b0;
  initial forever begin
    @(posedge vga_clk);
    #1;
    if (!reset_n) begin
      s1v = 1'b0; s2v = 1'b0;
    end else begin
      if (s2v) check("rgb", 32'({red, green, blue}), 32'(s2.rgb));
      if (s1v) begin
        if (s1.chk_addr) check("rom_addr", 32'(rom_addr), 32'(s1.addr));
        check("rom_piece", 32'(rom_piece), 32'(s1.piece));
      end
      s2 = s1; s2v = s1v;
      if (exp_q.size() > 0) begin
        s1 = exp_q.pop_front(); s1v = 1'b1;
      end else begin
        s1v = 1'b0;
      end
    end
  end

  task automatic do_write(input int sq, input int piece, input int pre_cycles);
    int  a0, n;
    bit  seen;
    wr_sq = 6'(sq); wr_piece = 4'(piece); wr_req = 1'b1;
    a0 = ack_cnt;
    if (pre_cycles > 0) begin
      drive_pixel(80 + (sq % 8) * 60 + 5, (sq / 8) * 60 + 5, 1'b1, 1'b0, 0);
      drive_pixel(300, 100, 1'b1, 1'b0, 0);
      for (int i = 2; i < pre_cycles; i++) rand_pixel(1'b1);
      check("no_ack_in_frame", 32'(ack_cnt), 32'(a0));
    end
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      drive_pixel(int'($urandom_range(0, 639)), int'($urandom_range(480, 524)), 1'b0, 1'b0, 0);
      n++;
      if (ack_cnt != a0) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 32'(0), 32'(1));
    else if (pre_cycles == 0) check("vb_latency", 32'(n), 32'(4));
    model_board[sq] = 4'(piece);
    repeat (10) drive_pixel(10, 500, 1'b0, 1'b0, 0);
    check("single_ack", 32'(ack_cnt - a0), 32'(1));
    wr_req = 1'b0;
    repeat (2) drive_pixel(10, 500, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int a0;
    model_reset();
    repeat (3) tick();
    check("rst_rgb", 32'({red, green, blue}), 32'(0));
    check("rst_rom_addr", 32'(rom_addr), 32'(0));
    check("rst_rom_piece", 32'(rom_piece), 32'(0));
    check("rst_wr_ack", 32'(wr_ack), 32'(0));
    reset_n = 1'b1;
    tick();

    // Directed pixels: top-left corner, bottom corner of a pawn square, off-board, blanked, selection.
    drive_pixel(80, 0, 1'b1, 1'b0, 0);
    drive_pixel(199, 419, 1'b1, 1'b0, 0);
    drive_pixel(40, 200, 1'b1, 1'b0, 0);
    drive_pixel(300, 200, 1'b0, 1'b0, 0);
    drive_pixel(270, 190, 1'b1, 1'b1, 27);
    drive_pixel(559, 479, 1'b1, 1'b0, 0);
    drive_pixel(560, 10, 1'b1, 1'b0, 0);
    for (int i = 0; i < 200; i++) rand_pixel(1'b0);

    // Write during active video, then hold-off and a second write after re-raise.
    do_write(36, 5, 20);
    drive_pixel(325, 245, 1'b1, 1'b0, 0);
    do_write(0, 0, 0);
    drive_pixel(85, 5, 1'b1, 1'b0, 0);
    for (int i = 0; i < 100; i++) rand_pixel(1'b1);

    // Reset while the FSM waits for vertical blank.
    repeat (3) tick();
    a0 = ack_cnt;
    wr_sq = 6'd36; wr_piece = 4'd13; wr_req = 1'b1;
    DrawX = 10'd300; DrawY = 10'd100; blank = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_rgb", 32'({red, green, blue}), 32'(0));
    check("midrst_rom_piece", 32'(rom_piece), 32'(0));
    wr_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    drive_pixel(325, 245, 1'b1, 1'b0, 0);
    drive_pixel(85, 5, 1'b1, 1'b0, 0);
    repeat (30) drive_pixel(10, 500, 1'b0, 1'b0, 0);
    check("midrst_no_ack", 32'(ack_cnt), 32'(a0));
    do_write(27, 14, 8);
    drive_pixel(270, 190, 1'b1, 1'b1, 27);
    for (int i = 0; i < 100; i++) rand_pixel(1'b0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/board_render_ctrl.md
BOARD_RENDER_CTRL -- requirements
Module: board_render_ctrl

Interface
REQ-001 The block SHALL have one clock, vga_clk; reset is asynchronous and active-low, port reset_n.
REQ-002 vga_clk  in  1  pixel clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 DrawX, DrawY  in  10 each  current pixel coordinates from the VGA controller.
REQ-005 blank  in  1  high = active video.
REQ-006 wr_req  in  1  board-write request, held high until wr_ack is seen.
REQ-007 wr_sq  in  6  target square, row*8+col, row 0 = top rank.
REQ-008 wr_piece  in  4  piece code to write: 0 empty, 1-6 white P N B R Q K, 9-14 black P N B R Q K.
REQ-009 sel_valid, sel_sq  in  1, 6  highlighted-square enable and index.
REQ-010 rom_q  in  4  palette index returned by the shared 60x60 sprite ROM.
REQ-011 pal_rgb  in  12  palette colour {r,g,b} for rom_piece/rom_q.
REQ-012 rom_addr  out  12  sprite ROM address.
REQ-013 rom_piece  out  4  sprite/palette select, same code set as wr_piece.
REQ-014 wr_ack  out  1  one-cycle write-commit acknowledge.
REQ-015 red, green, blue  out  4 each  registered pixel colour.

Function
REQ-016 Board area SHALL be x 80..559, y 0..479, 8x8 squares of 60x60 px; col=(DrawX-80)/60, row=DrawY/60, ox=(DrawX-80)%60, oy=DrawY%60.
REQ-017 The block SHALL hold a 64-entry x 4-bit board store, written only by the write FSM.
REQ-018 Edge k: register in_board, row, col, ox, oy and blank from DrawX/DrawY/blank.
REQ-019 Edge k+1: rom_addr SHALL be oy*60+ox (max 3599), and rom_piece the board entry at row*8+col; rom_piece=0 when not in_board.
REQ-020 The ROM is read on the falling edge, so rom_q/pal_rgb are valid at edge k+2; red/green/blue for the pixel sampled at edge k SHALL update at edge k+2, with blank pipelined identically.
REQ-021 Square colour: light 0xEDB when (row+col) even, dark 0x853 when odd; 0x6C4 when sel_valid and square==sel_sq, with sel sampled at edge k.
REQ-022 Output colour priority: blank low -> 0x000; not in_board -> 0x000; rom_piece==0 or rom_q==0 (transparent) -> square colour; else pal_rgb.
REQ-023 Write FSM states: IDLE, WAIT_VB, COMMIT, ACK, HOLD.
REQ-024 IDLE->WAIT_VB on wr_req high; wr_sq/wr_piece captured on that edge.
REQ-025 WAIT_VB->COMMIT on the first edge with DrawY>=480 (vertical blank); stays otherwise.
REQ-026 COMMIT writes the captured code into the store (one cycle) ->ACK; ACK drives wr_ack=1 for exactly one cycle ->HOLD.
REQ-027 HOLD->IDLE when wr_req low; a wr_req still high in HOLD SHALL NOT start a new write.
REQ-028 A request made while DrawY>=480 SHALL commit on the next edge (WAIT_VB lasts one cycle).
REQ-029 The store SHALL never change while DrawY<480, so a frame never shows a partial update.
REQ-030 Reads and a commit to the same square in one cycle: the read returns the old value.

Reset
REQ-031 On reset_n low: red/green/blue=0, rom_addr=0, rom_piece=0, wr_ack=0, FSM=IDLE, pipeline blank stages=0.
REQ-032 On reset the store SHALL load the start position: row0 12,10,11,13,14,11,10,12; row1 all 9; rows2-5 0; row6 all 1; row7 4,2,3,5,6,3,2,4.
REQ-033 Reset during any FSM state SHALL abandon the write without wr_ack and without altering the restored position.

Verification
REQ-034 Reset, DrawX=80, DrawY=0, blank=1 -> edge k+1 rom_addr=0, rom_piece=12; rom_q=0 -> edge k+2 RGB=0xEDB.
REQ-035 DrawX=199, DrawY=419 (row6 col1, ox=59, oy=59) -> rom_addr=3599, rom_piece=1; rom_q=5, pal_rgb=0xFFF -> RGB=0xFFF.
REQ-036 DrawX=40 or blank=0 anywhere -> RGB=0x000 two edges later; sel_valid=1, sel_sq=27, pixel in square 27 on an empty square -> 0x6C4.
REQ-037 wr_req with wr_sq=36, wr_piece=5 at DrawY=100 -> no store change until DrawY=480; commit, single wr_ack pulse; next frame square 36 yields rom_piece=5.
REQ-038 wr_req held high 10 cycles after wr_ack -> exactly one ack; drop and re-raise -> second write proceeds.
REQ-039 reset_n low while in WAIT_VB -> no wr_ack, square retains start-position code, FSM IDLE.
